// File: rtl/sum_tree_pipe.sv
// sum_tree_pipe: pipelined N-input unsigned adder tree with valid/ready flow control.
//
// Adds N unsigned W-bit channels through a binary adder tree. The tree has
// L = $clog2(N) levels and one register stage per level, so the latency is L cycles.
// A single global enable stalls every stage together. The enable is
// en = out_ready | ~out_valid, so leading bubbles still drain while the
// downstream is not ready.
//
// Parameters:
//   N  - number of input channels (2..16)
//   W  - width of each channel
//   OW - output width (1..W+$clog2(N)); below the natural width the result
//        wraps (low bits), or saturates when SUM_OVF_EN is defined
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   in_valid  in_data carries a valid operand set
//   in_ready  pipeline accepts a set this cycle (combinational, equals en)
//   in_data   channel i at bits [i*W +: W]
//   out_valid out_sum holds a valid result
//   out_ready downstream accepts the result
//   out_sum   registered sum of the accepted set
//   out_ovf   (SUM_OVF_EN only) result saturated because it exceeded OW bits
//
// Optional feature macro: SUM_OVF_EN (saturation plus the out_ovf flag).
module sum_tree_pipe #(
  parameter int N  = 3,
  parameter int W  = 8,
  parameter int OW = W + $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_sum
`ifdef SUM_OVF_EN
  ,
  output logic            out_ovf
`endif
);

  localparam int L  = $clog2(N);
  localparam int NW = W + L;

  logic         en_s;
  logic [L-1:0] vld_r;

  // The valid bit of the last level is the output valid.
  assign out_valid = vld_r[L-1];
  assign en_s      = out_ready | ~out_valid;
  assign in_ready  = en_s;

  // Per-level valid bits: shift in in_valid while enabled, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_r <= '0;
    end else if (en_s) begin
      vld_r <= L'({vld_r, in_valid});
    end else begin
      vld_r <= vld_r;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    // PCNT operands of width IWK enter this level; CNT sums of width OWK leave it.
    localparam int PCNT = (N + (1 << k) - 1) >> k;
    localparam int CNT  = (N + (1 << (k + 1)) - 1) >> (k + 1);
    localparam int IWK  = W + k;
    localparam int OWK  = W + k + 1;

    logic [PCNT*IWK-1:0] src_s;
    logic [CNT*OWK-1:0]  nxt_s;
    logic                src_vld_s;

    if (k == 0) begin : g_src_in
      assign src_s     = in_data;
      assign src_vld_s = in_valid;
    end else begin : g_src_lvl
      assign src_s     = g_lvl[k-1].g_reg.data_r;
      assign src_vld_s = vld_r[k-1];
    end

    for (genvar j = 0; j < CNT; j++) begin : g_node
      if (2 * j + 1 < PCNT) begin : g_add
        assign nxt_s[j*OWK +: OWK] = OWK'(src_s[2*j*IWK +: IWK])
                                   + OWK'(src_s[(2*j+1)*IWK +: IWK]);
      end else begin : g_pass
        // Odd leftover operand: zero-extended into the next level.
        assign nxt_s[j*OWK +: OWK] = OWK'(src_s[2*j*IWK +: IWK]);
      end
    end

    // The last level is registered as out_sum below, after width reduction.
    if (k < L - 1) begin : g_reg
      logic [CNT*OWK-1:0] data_r;

      // Level register: loads only valid partial sums so bubbles leave data untouched.
      always_ff @(posedge clk) begin
        if (!rst) begin
          data_r <= '0;
        end else if (en_s && src_vld_s) begin
          data_r <= nxt_s;
        end else begin
          data_r <= data_r;
        end
      end
    end
  end

  logic [NW-1:0] fin_s;
  logic          fin_vld_s;
  logic [OW-1:0] red_s;
`ifdef SUM_OVF_EN
  logic          ovf_s;
`endif

  assign fin_s     = g_lvl[L-1].nxt_s;
  assign fin_vld_s = g_lvl[L-1].src_vld_s;

  if (OW < NW) begin : g_narrow
`ifdef SUM_OVF_EN
    // Any set bit above OW means the sum does not fit: saturate.
    assign ovf_s = |fin_s[NW-1:OW];
    assign red_s = ovf_s ? {OW{1'b1}} : fin_s[OW-1:0];
`else
    // Wrap-around: the high bits are deliberately discarded.
    logic [NW-OW-1:0] unused_hi_s;
    assign unused_hi_s = fin_s[NW-1:OW];
    assign red_s       = fin_s[OW-1:0];
`endif
  end else begin : g_full
    assign red_s = fin_s;
`ifdef SUM_OVF_EN
    assign ovf_s = 1'b0;
`endif
  end

  // Output register: holds during stalls and across bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_sum <= '0;
    end else if (en_s && fin_vld_s) begin
      out_sum <= red_s;
    end else begin
      out_sum <= out_sum;
    end
  end

`ifdef SUM_OVF_EN
  // Overflow flag is registered together with out_sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_ovf <= 1'b0;
    end else if (en_s && fin_vld_s) begin
      out_ovf <= ovf_s;
    end else begin
      out_ovf <= out_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_sum_tree_pipe.sv
// Self-checking bench for sum_tree_pipe: three instances
// (default N=3/W=8, narrowed OW=9, and N=5/W=4), directed vectors with
// hand-computed expectations.
module tb_sum_tree_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A: defaults (N=3, W=8, OW=10)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [23:0] a_in_data;
  logic [9:0]  a_out_sum;
  // Instance B: N=3, W=8, OW=9
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [23:0] b_in_data;
  logic [8:0]  b_out_sum;
  // Instance C: N=5, W=4 (OW=7)
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [19:0] c_in_data;
  logic [6:0]  c_out_sum;
`ifdef SUM_OVF_EN
  logic        a_out_ovf, b_out_ovf, c_out_ovf;
  localparam logic [8:0] B_EXP = 9'd511;
`else
  localparam logic [8:0] B_EXP = 9'd253;
`endif

  sum_tree_pipe #(.N(3), .W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum)
`ifdef SUM_OVF_EN
    , .out_ovf(a_out_ovf)
`endif
  );

  sum_tree_pipe #(.N(3), .W(8), .OW(9)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum)
`ifdef SUM_OVF_EN
    , .out_ovf(b_out_ovf)
`endif
  );

  sum_tree_pipe #(.N(5), .W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum)
`ifdef SUM_OVF_EN
    , .out_ovf(c_out_ovf)
`endif
  );

  typedef struct {
    logic [23:0] data;
    logic [9:0]  exp;
  } vec_t;

  vec_t vecs [4];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{data: {8'd3,   8'd2,  8'd1},   exp: 10'd6};
    vecs[1] = '{data: {8'd30,  8'd20, 8'd10},  exp: 10'd60};
    vecs[2] = '{data: {8'd0,   8'd0,  8'd0},   exp: 10'd0};
    vecs[3] = '{data: {8'd155, 8'd0,  8'd100}, exp: 10'd255};

    rst = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = 24'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = 24'd0;
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_in_data = 20'd0;

    // Reset state
    tick(); tick();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_sum", 32'(a_out_sum), 32'd0);
    rst = 1'b1;
    tick();
    check("rel_in_ready", 32'(a_in_ready), 32'd1);

    // Single set, latency 2
    a_in_data = {8'd255, 8'd255, 8'd255}; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("lat_early_valid", 32'(a_out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(a_out_valid), 32'd1);
    check("lat_sum", 32'(a_out_sum), 32'd765);
`ifdef SUM_OVF_EN
    check("full_width_ovf", 32'(a_out_ovf), 32'd0);
`endif
    tick();
    check("lat_after_valid", 32'(a_out_valid), 32'd0);

    // Back-to-back streaming from the table
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        a_in_data = vecs[i].data; a_in_valid = 1'b1;
        #1;
        check("stream_in_ready", 32'(a_in_ready), 32'd1);
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check("stream_valid", 32'(a_out_valid), 32'd1);
        check("stream_sum", 32'(a_out_sum), 32'(vecs[i-1].exp));
      end
    end
    tick();
    check("stream_drained", 32'(a_out_valid), 32'd0);

    // Stall with changing in_data
    a_in_data = {8'd6, 8'd5, 8'd4}; a_in_valid = 1'b1;
    tick();
    a_in_data = {8'd8, 8'd8, 8'd8};
    tick();
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", 32'(a_out_valid), 32'd1);
      check("stall_sum", 32'(a_out_sum), 32'd15);
      check("stall_in_ready", 32'(a_in_ready), 32'd0);
      a_in_data = {8'(i + 40), 8'(i + 9), 8'd77};
      tick();
    end
    a_out_ready = 1'b1; a_in_valid = 1'b0;
    #1;
    check("release_sum", 32'(a_out_sum), 32'd15);
    check("release_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    check("release_next_valid", 32'(a_out_valid), 32'd1);
    check("release_next_sum", 32'(a_out_sum), 32'd24);
    tick();
    check("release_drained", 32'(a_out_valid), 32'd0);

    // Reset mid-stream discards the in-flight set
    a_in_data = {8'd7, 8'd7, 8'd7}; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("midrst_valid", 32'(a_out_valid), 32'd0);
      check("midrst_sum", 32'(a_out_sum), 32'd0);
      tick();
    end
    a_in_data = {8'd2, 8'd2, 8'd2}; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(a_out_valid), 32'd1);
    check("post_rst_sum", 32'(a_out_sum), 32'd6);

    // Narrowed output OW=9
    b_in_data = {8'd255, 8'd255, 8'd255}; b_in_valid = 1'b1;
    tick();
    b_in_data = {8'd1, 8'd1, 8'd1};
    tick();
    b_in_valid = 1'b0;
    check("ow9_valid", 32'(b_out_valid), 32'd1);
    check("ow9_sum", 32'(b_out_sum), 32'(B_EXP));
`ifdef SUM_OVF_EN
    check("ow9_ovf", 32'(b_out_ovf), 32'd1);
`endif
    tick();
    check("ow9_small_sum", 32'(b_out_sum), 32'd3);
`ifdef SUM_OVF_EN
    check("ow9_small_ovf", 32'(b_out_ovf), 32'd0);
`endif
    tick();
    check("ow9_drained", 32'(b_out_valid), 32'd0);
    check("ow9_in_ready", 32'(b_in_ready), 32'd1);

    // N=5, W=4: three levels and an odd leftover channel
    c_in_data = {5{4'd15}}; c_in_valid = 1'b1;
    tick();
    c_in_data = {4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
    tick();
    c_in_valid = 1'b0;
    check("n5_early_valid", 32'(c_out_valid), 32'd0);
    tick();
    check("n5_valid", 32'(c_out_valid), 32'd1);
    check("n5_sum_max", 32'(c_out_sum), 32'd75);
    tick();
    check("n5_sum_leftover", 32'(c_out_sum), 32'd2);
`ifdef SUM_OVF_EN
    check("n5_ovf", 32'(c_out_ovf), 32'd0);
`endif
    tick();
    check("n5_drained", 32'(c_out_valid), 32'd0);
    check("n5_in_ready", 32'(c_in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
